// File: rtl/except_ctrl.sv
// Exception sequencer: picks the highest-priority fault/interrupt of the memory-stage
// instruction, nullifies the pipeline, and redirects fetch to the IVT vector.
module except_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int IVT_OFS_BITS = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_exec_stall,
    input  logic                             i_mem_stall,
    input  logic                             i_fetch_stall,
    input  logic                             i_valid_p3,
    input  logic [ADDR_WIDTH-1:0]            i_pc_p3,
    input  logic                             i_dly_slt_p3,
    input  logic [ADDR_WIDTH-1:0]            i_pc_br_p3,
    input  logic                             i_bus_err_p3,
    input  logic                             i_dec_err_p3,
    input  logic                             i_syscall_p3,
    input  logic                             i_break_p3,
    input  logic                             i_irq,
    input  logic [ADDR_WIDTH-IVT_OFS_BITS-1:0] i_cop0_ivtbase,
    input  logic                             i_cop0_ie,
    output logic                             o_except_start,
    output logic                             o_except_dly_slt,
    output logic [ADDR_WIDTH-1:0]            o_except_raddr,
    output logic [ADDR_WIDTH-1:0]            o_except_raddr_dly,
    output logic                             o_nullify_decode,
    output logic                             o_nullify_execute,
    output logic                             o_nullify_mem,
    output logic                             o_nullify_wb,
    output logic                             o_jump,
    output logic [ADDR_WIDTH-1:0]            o_jump_addr,
    output logic [2:0]                       o_cause
);

    // state | meaning
    // IDLE  | watching p3 for an event; takes it on the first unstalled valid cycle
    // FLUSH | redirect issued; kill decode/execute until the pipeline advances

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t state_q, state_d;
    logic   irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= i_irq;
        end
    end

    logic                    stall;
    logic                    evt;
    logic [2:0]              cause;
    logic [IVT_OFS_BITS-1:0] offset;

    assign stall = i_exec_stall | i_mem_stall | i_fetch_stall;

    always_comb begin
        evt    = 1'b1;
        cause  = 3'd0;
        offset = '0;
        if (i_bus_err_p3) begin
            cause  = 3'd1;
            offset = IVT_OFS_BITS'(12'h000);
        end else if (i_dec_err_p3) begin
            cause  = 3'd2;
            offset = IVT_OFS_BITS'(12'h004);
        end else if (i_syscall_p3) begin
            cause  = 3'd3;
            offset = IVT_OFS_BITS'(12'h008);
        end else if (i_break_p3) begin
            cause  = 3'd4;
            offset = IVT_OFS_BITS'(12'h00C);
        end else if (irq_q && i_cop0_ie) begin
            cause  = 3'd5;
            offset = IVT_OFS_BITS'(12'h010);
        end else begin
            evt    = 1'b0;
        end
    end

    always_comb begin
        state_d            = state_q;
        o_except_start     = 1'b0;
        o_except_dly_slt   = 1'b0;
        o_except_raddr     = '0;
        o_except_raddr_dly = '0;
        o_nullify_decode   = 1'b0;
        o_nullify_execute  = 1'b0;
        o_nullify_mem      = 1'b0;
        o_nullify_wb       = 1'b0;
        o_jump             = 1'b0;
        o_jump_addr        = '0;
        o_cause            = 3'd0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (!stall && i_valid_p3 && evt) begin
                        o_except_start     = 1'b1;
                        o_jump             = 1'b1;
                        o_nullify_decode   = 1'b1;
                        o_nullify_execute  = 1'b1;
                        o_nullify_mem      = 1'b1;
                        o_nullify_wb       = 1'b1;
                        o_except_dly_slt   = i_dly_slt_p3;
                        o_except_raddr     = i_pc_p3;
                        o_except_raddr_dly = i_pc_br_p3;
                        o_jump_addr        = {i_cop0_ivtbase, offset};
                        o_cause            = cause;
                        state_d            = FLUSH;
                    end
                end
                FLUSH: begin
                    o_nullify_decode  = 1'b1;
                    o_nullify_execute = 1'b1;
                    if (!stall) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_except_ctrl.sv
// Directed self-checking bench for except_ctrl with hand-computed expectations.
module tb_except_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_exec_stall, i_mem_stall, i_fetch_stall;
    logic        i_valid_p3;
    logic [31:0] i_pc_p3;
    logic        i_dly_slt_p3;
    logic [31:0] i_pc_br_p3;
    logic        i_bus_err_p3, i_dec_err_p3, i_syscall_p3, i_break_p3;
    logic        i_irq;
    logic [21:0] i_cop0_ivtbase;
    logic        i_cop0_ie;
    logic        o_except_start, o_except_dly_slt;
    logic [31:0] o_except_raddr, o_except_raddr_dly;
    logic        o_nullify_decode, o_nullify_execute, o_nullify_mem, o_nullify_wb;
    logic        o_jump;
    logic [31:0] o_jump_addr;
    logic [2:0]  o_cause;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    except_ctrl dut (
        .clk(clk), .rst(rst),
        .i_exec_stall(i_exec_stall), .i_mem_stall(i_mem_stall), .i_fetch_stall(i_fetch_stall),
        .i_valid_p3(i_valid_p3), .i_pc_p3(i_pc_p3), .i_dly_slt_p3(i_dly_slt_p3),
        .i_pc_br_p3(i_pc_br_p3), .i_bus_err_p3(i_bus_err_p3), .i_dec_err_p3(i_dec_err_p3),
        .i_syscall_p3(i_syscall_p3), .i_break_p3(i_break_p3), .i_irq(i_irq),
        .i_cop0_ivtbase(i_cop0_ivtbase), .i_cop0_ie(i_cop0_ie),
        .o_except_start(o_except_start), .o_except_dly_slt(o_except_dly_slt),
        .o_except_raddr(o_except_raddr), .o_except_raddr_dly(o_except_raddr_dly),
        .o_nullify_decode(o_nullify_decode), .o_nullify_execute(o_nullify_execute),
        .o_nullify_mem(o_nullify_mem), .o_nullify_wb(o_nullify_wb),
        .o_jump(o_jump), .o_jump_addr(o_jump_addr), .o_cause(o_cause)
    );

    wire [3:0] nul = {o_nullify_wb, o_nullify_mem, o_nullify_execute, o_nullify_decode};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling mid-cycle.
    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        i_exec_stall = 0; i_mem_stall = 0; i_fetch_stall = 0;
        i_valid_p3 = 0; i_pc_p3 = '0; i_dly_slt_p3 = 0; i_pc_br_p3 = '0;
        i_bus_err_p3 = 0; i_dec_err_p3 = 0; i_syscall_p3 = 0; i_break_p3 = 0;
        i_irq = 0;
    endtask

    initial begin
        int starts;
        clear_inputs();
        i_cop0_ivtbase = 22'h3FFFFF;
        i_cop0_ie      = 0;
        rst            = 1;
        // events present during reset must not reach the outputs
        i_valid_p3 = 1; i_bus_err_p3 = 1; i_pc_p3 = 32'h100;
        tick(); tick(); settle();
        check("rst_start", 32'(o_except_start), 32'd0);
        check("rst_nullify", 32'(nul), 32'd0);
        check("rst_jump", 32'(o_jump), 32'd0);
        check("rst_jaddr", o_jump_addr, 32'd0);
        rst = 0;

        // bus error beats syscall
        i_syscall_p3 = 1;
        settle();
        check("be_start", 32'(o_except_start), 32'd1);
        check("be_jump", 32'(o_jump), 32'd1);
        check("be_nullify", 32'(nul), 32'hF);
        check("be_cause", 32'(o_cause), 32'd1);
        check("be_jaddr", o_jump_addr, 32'hFFFFFC00);
        check("be_raddr", o_except_raddr, 32'h100);
        tick(); settle();
        check("flush_nullify", 32'(nul), 32'h3);
        check("flush_start", 32'(o_except_start), 32'd0);
        check("flush_jump", 32'(o_jump), 32'd0);
        // flags still held: earliest retake is the cycle after FLUSH
        tick(); settle();
        check("b2b_start", 32'(o_except_start), 32'd1);
        clear_inputs();
        tick(); tick(); settle();
        check("idle_nullify", 32'(nul), 32'd0);

        // interrupt on a delay slot, seen one cycle after i_irq rises
        i_cop0_ivtbase = 22'h0ABCDE;
        i_cop0_ie = 1; i_irq = 1; i_valid_p3 = 1; i_dly_slt_p3 = 1;
        i_pc_p3 = 32'h204; i_pc_br_p3 = 32'h200;
        settle();
        check("irq_lat_start", 32'(o_except_start), 32'd0);
        tick(); settle();
        check("irq_start", 32'(o_except_start), 32'd1);
        check("irq_dly", 32'(o_except_dly_slt), 32'd1);
        check("irq_raddr_dly", o_except_raddr_dly, 32'h200);
        check("irq_raddr", o_except_raddr, 32'h204);
        check("irq_cause", 32'(o_cause), 32'd5);
        check("irq_jaddr", o_jump_addr, 32'h2AF37810);
        clear_inputs();
        tick(); tick(); settle();

        // masked interrupt, then unmask
        i_cop0_ie = 0; i_irq = 1; i_valid_p3 = 1; i_pc_p3 = 32'h300;
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            tick(); settle();
            if (o_except_start) starts++;
        end
        check("mask_nostart", 32'(starts), 32'd0);
        i_cop0_ie = 1;
        settle();
        check("unmask_start", 32'(o_except_start), 32'd1);
        check("unmask_cause", 32'(o_cause), 32'd5);
        check("unmask_raddr", o_except_raddr, 32'h300);
        clear_inputs();
        tick(); tick(); settle();

        // stall before the take and during FLUSH
        i_valid_p3 = 1; i_syscall_p3 = 1; i_pc_p3 = 32'h400; i_mem_stall = 1;
        starts = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            if (o_except_start || nul != 4'h0) starts++;
            tick();
        end
        check("stall_quiet", 32'(starts), 32'd0);
        i_mem_stall = 0;
        settle();
        check("stall_take", 32'(o_except_start), 32'd1);
        check("stall_cause", 32'(o_cause), 32'd3);
        check("stall_ofs", 32'(o_jump_addr[9:0]), 32'h008);
        tick();
        i_exec_stall = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("fstall_nullify", 32'(nul), 32'h3);
            check("fstall_start", 32'(o_except_start), 32'd0);
            tick();
        end
        clear_inputs();
        settle();
        check("fstall_last", 32'(nul), 32'h3);
        tick(); settle();
        check("fstall_idle", 32'(nul), 32'd0);

        // bubble masks events; decode error beats break
        i_valid_p3 = 0; i_break_p3 = 1;
        settle();
        check("bubble_start", 32'(o_except_start), 32'd0);
        tick(); settle();
        check("bubble_start2", 32'(o_except_start), 32'd0);
        i_valid_p3 = 1; i_dec_err_p3 = 1; i_pc_p3 = 32'h500;
        settle();
        check("de_cause", 32'(o_cause), 32'd2);
        check("de_jaddr", o_jump_addr, 32'h2AF37804);
        clear_inputs();
        tick(); tick(); settle();

        // reset during FLUSH
        i_valid_p3 = 1; i_break_p3 = 1; i_pc_p3 = 32'h600;
        settle();
        check("brk_cause", 32'(o_cause), 32'd4);
        check("brk_ofs", 32'(o_jump_addr[9:0]), 32'h00C);
        tick();
        clear_inputs();
        rst = 1;
        settle();
        check("rstf_nullify", 32'(nul), 32'd0);
        check("rstf_start", 32'(o_except_start), 32'd0);
        tick();
        rst = 0;
        settle();
        check("rstf_idle", 32'(nul), 32'd0);
        tick(); settle();
        check("rstf_idle2", 32'(nul), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
